cam_capture_rgb444: RTL and testbench

Camera capture stage between the OV7670 parallel pixel bus and `buffer_ram_dp`. Samples byte-serial RGB565 data on the camera pixel clock, assembles each two-byte pixel, reduces it to RGB444 and drives the write port of the dual-port frame buffer (`addr_in`, `data_in`, `regwrite`). Captures only whole frames delimited by VSYNC. Flags frames that overflow the buffer.

---
 rtl/cam_capture_rgb444.sv | 130 +++++++++++++
 tb/tb_cam_capture_rgb444.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_rgb444.sv
// OV7670 capture: assembles byte-serial RGB565 pixels, truncates to RGB444 and
// writes them linearly into the frame buffer, one whole VSYNC-delimited frame at a time.
//
// state   | meaning
// SYNC    | after reset, wait for vsync high so a partial frame is never captured
// VWAIT   | vertical blanking, wait for vsync low to start a frame
// BYTE_HI | expecting the high byte of a pixel
// BYTE_LO | high byte held, expecting the low byte
module cam_capture_rgb444 #(
  parameter int AW           = 15,
  parameter int DW           = 12,
  parameter int CAM_SCREEN_X = 160,
  parameter int CAM_SCREEN_Y = 120
) (
  input  logic          CAM_pclk,
  input  logic          rst,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic [7:0]    CAM_px_data,
  output logic          DP_RAM_regW,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [DW-1:0] DP_RAM_data_in,
  output logic          frame_done,
  output logic          overflow
);

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    VWAIT   = 2'd1,
    BYTE_HI = 2'd2,
    BYTE_LO = 2'd3
  } state_t;

  // One extra pointer bit keeps the bound correct even when X*Y equals 2^AW.
  localparam logic [AW:0] NPIX = (AW+1)'(CAM_SCREEN_X * CAM_SCREEN_Y);

  state_t        state_q, state_d;
  logic [6:0]    hi_q, hi_d;
  logic [AW:0]   ptr_q, ptr_d;
  logic          regw_q, regw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic [11:0]   rgb444;

  // Only the kept bits of the high byte are stored: R5[4:1] and G6[5:3].
  assign rgb444 = {hi_q[6:3], hi_q[2:0], CAM_px_data[7], CAM_px_data[4:1]};

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    ptr_d   = ptr_q;
    regw_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    case (state_q)
      SYNC: begin
        if (CAM_vsync) state_d = VWAIT;
      end
      VWAIT: begin
        if (!CAM_vsync) begin
          state_d = BYTE_HI;
          ptr_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      BYTE_HI: begin
        if (CAM_vsync) begin
          done_d  = 1'b1;
          state_d = VWAIT;
        end else if (CAM_href) begin
          hi_d    = {CAM_px_data[7:4], CAM_px_data[2:0]};
          state_d = BYTE_LO;
        end
      end
      BYTE_LO: begin
        if (CAM_vsync) begin
          done_d  = 1'b1;
          state_d = VWAIT;
        end else begin
          // href low here means the line ended on an odd byte; the held byte is dropped.
          state_d = BYTE_HI;
          if (CAM_href) begin
            if (ptr_q < NPIX) begin
              regw_d = 1'b1;
              addr_d = ptr_q[AW-1:0];
              data_d = DW'(rgb444);
              ptr_d  = ptr_q + (AW+1)'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge CAM_pclk or negedge rst) begin
    if (!rst) begin
      state_q <= SYNC;
      hi_q    <= '0;
      ptr_q   <= '0;
      regw_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      ptr_q   <= ptr_d;
      regw_q  <= regw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign DP_RAM_regW    = regw_q;
  assign DP_RAM_addr_in = addr_q;
  assign DP_RAM_data_in = data_q;
  assign frame_done     = done_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_cam_capture_rgb444.sv
// Directed bench for cam_capture_rgb444: expected writes are queued when the low
// byte is driven and checked against the strobe one edge later.
module tb_cam_capture_rgb444;
  localparam int AW   = 15;
  localparam int DW   = 12;
  localparam int X    = 160;
  localparam int Y    = 120;
  localparam int NPIX = X * Y;

  logic          clk = 1'b0;
  logic          rst;
  logic          vsync;
  logic          href;
  logic [7:0]    px;
  logic          regw;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          fdone;
  logic          ovf;

  cam_capture_rgb444 #(.AW(AW), .DW(DW), .CAM_SCREEN_X(X), .CAM_SCREEN_Y(Y)) dut (
    .CAM_pclk      (clk),
    .rst           (rst),
    .CAM_vsync     (vsync),
    .CAM_href      (href),
    .CAM_px_data   (px),
    .DP_RAM_regW   (regw),
    .DP_RAM_addr_in(addr),
    .DP_RAM_data_in(data),
    .frame_done    (fdone),
    .overflow      (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            exp_ptr = 0;
  logic          exp_ovf = 1'b0;
  logic          exp_fd  = 1'b0;
  logic [AW-1:0] last_a  = '0;
  logic [DW-1:0] last_d  = '0;

  function automatic logic [11:0] to_rgb444(input logic [7:0] hi, input logic [7:0] lo);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = hi[7:3];
    g6 = {hi[2:0], lo[7:5]};
    b5 = lo[4:0];
    return {r5[4:1], g6[5:2], b5[4:1]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic vs, input logic hr, input logic [7:0] d);
    wr_t w;
    vsync = vs;
    href  = hr;
    px    = d;
    @(posedge clk);
    #1;
    check("strobe", 32'(regw), 32'(exp_q.size() != 0));
    if (regw && exp_q.size() != 0) begin
      w = exp_q.pop_front();
      check("addr", 32'(addr), 32'(w.a));
      check("data", 32'(data), 32'(w.d));
      last_a = w.a;
      last_d = w.d;
    end else if (!regw) begin
      check("hold_addr", 32'(addr), 32'(last_a));
      check("hold_data", 32'(data), 32'(last_d));
    end
    check("frame_done", 32'(fdone), 32'(exp_fd));
    check("overflow", 32'(ovf), 32'(exp_ovf));
  endtask

  task automatic pixel(input logic [7:0] hi, input logic [7:0] lo);
    wr_t w;
    step(1'b0, 1'b1, hi);
    if (exp_ptr < NPIX) begin
      w.a = AW'(exp_ptr);
      w.d = to_rgb444(hi, lo);
      exp_q.push_back(w);
      exp_ptr++;
    end else begin
      exp_ovf = 1'b1;
    end
    step(1'b0, 1'b1, lo);
  endtask

  task automatic frame_start();
    step(1'b1, 1'b0, 8'h00);
    exp_ptr = 0;
    exp_ovf = 1'b0;
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic frame_end();
    exp_fd = 1'b1;
    step(1'b1, 1'b0, 8'h00);
    exp_fd = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_regw"}, 32'(regw), 32'd0);
    check({tag, "_addr"}, 32'(addr), 32'd0);
    check({tag, "_data"}, 32'(data), 32'd0);
    check({tag, "_done"}, 32'(fdone), 32'd0);
    check({tag, "_ovf"},  32'(ovf), 32'd0);
  endtask

  initial begin
    rst   = 1'b0;
    vsync = 1'b0;
    href  = 1'b0;
    px    = 8'h00;
    #2;
    check_all_zero("reset");

    // Reset held with href toggling: everything stays at zero.
    for (int i = 0; i < 4; i++) step(1'b0, 1'(i % 2), 8'(i * 17));
    rst = 1'b1;

    // Out of reset mid-frame: no capture until a full vsync 1->0.
    for (int i = 0; i < 12; i++) step(1'b0, 1'(i % 2), 8'(8'h30 + i));

    frame_start();
    pixel(8'hF8, 8'h1F);
    pixel(8'h07, 8'hE0);
    step(1'b0, 1'b0, 8'h00);

    // Line ending on an odd byte, then a fresh line.
    pixel(8'h12, 8'h34);
    pixel(8'h56, 8'h78);
    step(1'b0, 1'b1, 8'h9A);
    step(1'b0, 1'b0, 8'h00);
    pixel(8'hAB, 8'hCD);
    step(1'b0, 1'b0, 8'h00);

    // vsync rising on the low-byte edge wins over href: no write, frame_done.
    step(1'b0, 1'b1, 8'h11);
    exp_fd = 1'b1;
    step(1'b1, 1'b1, 8'h22);
    exp_fd = 1'b0;
    step(1'b1, 1'b0, 8'h00);

    // Full frame, then one extra partial line to overflow the buffer.
    frame_start();
    for (int l = 0; l < Y; l++) begin
      for (int c = 0; c < X; c++) pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      step(1'b0, 1'b0, 8'h00);
    end
    for (int c = 0; c < 10; c++) pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    frame_end();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
    frame_start();

    // Asynchronous reset right after the 500th write of a frame.
    for (int c = 0; c < 500; c++) pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    last_a  = '0;
    last_d  = '0;
    exp_ovf = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hEE);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0, 1'(i % 2), 8'($urandom_range(0, 255)));

    frame_start();
    pixel(8'h5A, 8'hC3);
    pixel(8'hFF, 8'hFF);
    frame_end();
    step(1'b1, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
